// File: rtl/global_reset.sv
// rtl/global_reset.sv - board reset generator: power-on-only and global active-low resets
// Power-on state comes from register initial values, so the flops below carry declaration initialisers.
module global_reset #(
    parameter int POR_CYCLES  = 50000,
    parameter int HOLD_CYCLES = 500000
) (
    input  logic clock_i,
    input  logic forced_reset_i,
    output logic n_reset_o,
    output logic n_limited_reset_o
);

    localparam int PW = (POR_CYCLES > 2) ? $clog2(POR_CYCLES) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [PW-1:0] POR_LAST = PW'(POR_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    logic [PW-1:0] por_cnt   = '0;
    logic          n_limited = 1'b0;
    logic [1:0]    sync      = 2'b11;
    logic [HW-1:0] hold_cnt  = '0;
    logic          n_reset   = 1'b0;
    logic          forced_sync;
    logic [HW-1:0] hold_next;

    // Counter saturates one short of POR_CYCLES; the output flop latches high on that edge.
    always_ff @(posedge clock_i) begin
        if (por_cnt != POR_LAST) begin
            por_cnt <= por_cnt + PW'(1);
        end
        if (por_cnt == POR_LAST) begin
            n_limited <= 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge forced_reset_i) begin
        if (forced_reset_i) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], 1'b0};
        end
    end

    assign forced_sync = sync[1];

    always_comb begin
        hold_next = hold_cnt;
        if (!n_limited || forced_sync) begin
            hold_next = '0;
        end else if (hold_cnt != HOLD_MAX) begin
            hold_next = hold_cnt + HW'(1);
        end
    end

    // n_reset is asserted asynchronously but only ever released by a clock edge.
    always_ff @(posedge clock_i or posedge forced_reset_i) begin
        if (forced_reset_i) begin
            hold_cnt <= '0;
            n_reset  <= 1'b0;
        end else begin
            hold_cnt <= hold_next;
            n_reset  <= (hold_next == HOLD_MAX);
        end
    end

    assign n_reset_o         = n_reset;
    assign n_limited_reset_o = n_limited;

endmodule

// File: tb/tb_global_reset.sv
// tb/tb_global_reset.sv - randomized self-checking bench for global_reset
module tb_global_reset;

    localparam int POR  = 8;
    localparam int HOLD = 16;

    logic clock   = 1'b0;
    logic clk_en  = 1'b1;
    logic forced  = 1'b0;
    logic forced2 = 1'b0;
    logic n_reset, n_limited, n_reset2, n_limited2;

    int edge_cnt   = 0;
    int fall_edge  = 0;
    int fall_edge2 = 0;
    int rise_cnt   = 0;
    int checks     = 0;
    int errors     = 0;

    global_reset #(.POR_CYCLES(POR), .HOLD_CYCLES(HOLD)) dut (
        .clock_i(clock), .forced_reset_i(forced),
        .n_reset_o(n_reset), .n_limited_reset_o(n_limited));

    global_reset #(.POR_CYCLES(POR), .HOLD_CYCLES(HOLD)) dut_por (
        .clock_i(clock), .forced_reset_i(forced2),
        .n_reset_o(n_reset2), .n_limited_reset_o(n_limited2));

    initial forever begin
        #10;
        if (clk_en) clock = ~clock;
    end

    always @(posedge clock) edge_cnt++;
    always @(posedge n_reset) rise_cnt++;

    // Release edge = HOLD edges after the later of (last soft-reset fall + 2) and POR release.
    function automatic logic model_nres(logic f, int fe, int e);
        int start;
        if (f) return 1'b0;
        start = (fe + 2 > POR) ? fe + 2 : POR;
        return (e >= start + HOLD) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic model_nlim(int e);
        return (e >= POR) ? 1'b1 : 1'b0;
    endfunction

    task automatic test_reset();
        #5;
        checks++; if (n_limited !== 1'b0) begin errors++; $display("FAIL reset_nlim got=%b exp=0", n_limited); end
        checks++; if (n_reset !== 1'b0) begin errors++; $display("FAIL reset_nres got=%b exp=0", n_reset); end
        checks++; if (n_reset2 !== 1'b0) begin errors++; $display("FAIL reset_nres2 got=%b exp=0", n_reset2); end
        fork
            begin
                repeat (2) @(posedge clock);
                #3 forced2 = 1'b1;
                while (edge_cnt < 20) @(posedge clock);
                #3 forced2 = 1'b0;
                fall_edge2 = edge_cnt;
            end
            begin
                for (int i = 0; i < 44; i++) begin
                    @(negedge clock);
                    checks++; if (n_limited !== model_nlim(edge_cnt)) begin errors++; $display("FAIL por_nlim edge=%0d got=%b exp=%b", edge_cnt, n_limited, model_nlim(edge_cnt)); end
                    checks++; if (n_reset !== model_nres(forced, fall_edge, edge_cnt)) begin errors++; $display("FAIL por_nres edge=%0d got=%b exp=%b", edge_cnt, n_reset, model_nres(forced, fall_edge, edge_cnt)); end
                    checks++; if (n_limited2 !== model_nlim(edge_cnt)) begin errors++; $display("FAIL overlap_nlim edge=%0d got=%b exp=%b", edge_cnt, n_limited2, model_nlim(edge_cnt)); end
                    checks++; if (n_reset2 !== model_nres(forced2, fall_edge2, edge_cnt)) begin errors++; $display("FAIL overlap_nres edge=%0d got=%b exp=%b", edge_cnt, n_reset2, model_nres(forced2, fall_edge2, edge_cnt)); end
                end
            end
        join
    endtask

    task automatic test_soft_reset();
        int d;
        d = 2 + $urandom_range(5);
        @(posedge clock);
        #(d) forced = 1'b1;
        #1;
        checks++; if (n_reset !== 1'b0) begin errors++; $display("FAIL soft_immediate got=%b exp=0", n_reset); end
        repeat (5) begin
            @(negedge clock);
            checks++; if (n_reset !== 1'b0) begin errors++; $display("FAIL soft_held edge=%0d got=%b exp=0", edge_cnt, n_reset); end
            checks++; if (n_limited !== 1'b1) begin errors++; $display("FAIL soft_nlim edge=%0d got=%b exp=1", edge_cnt, n_limited); end
        end
        @(posedge clock);
        #3 forced = 1'b0;
        fall_edge = edge_cnt;
        for (int i = 0; i < 22; i++) begin
            @(negedge clock);
            checks++; if (n_reset !== model_nres(forced, fall_edge, edge_cnt)) begin errors++; $display("FAIL soft_release edge=%0d got=%b exp=%b", edge_cnt, n_reset, model_nres(forced, fall_edge, edge_cnt)); end
            checks++; if (n_limited !== 1'b1) begin errors++; $display("FAIL soft_nlim edge=%0d got=%b exp=1", edge_cnt, n_limited); end
        end
    endtask

    task automatic test_glitch();
        @(posedge clock);
        #4 forced = 1'b1;
        #1;
        checks++; if (n_reset !== 1'b0) begin errors++; $display("FAIL glitch_immediate got=%b exp=0", n_reset); end
        #2 forced = 1'b0;
        fall_edge = edge_cnt;
        for (int i = 0; i < 22; i++) begin
            @(negedge clock);
            checks++; if (n_reset !== model_nres(forced, fall_edge, edge_cnt)) begin errors++; $display("FAIL glitch_release edge=%0d got=%b exp=%b", edge_cnt, n_reset, model_nres(forced, fall_edge, edge_cnt)); end
        end
    endtask

    task automatic test_reassert();
        int r0;
        r0 = rise_cnt;
        @(posedge clock);
        #3 forced = 1'b1;
        repeat (2) @(posedge clock);
        #3 forced = 1'b0;
        fall_edge = edge_cnt;
        // After fall+12 edges the hold count is 10.
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            checks++; if (n_reset !== 1'b0) begin errors++; $display("FAIL reassert_hold edge=%0d got=%b exp=0", edge_cnt, n_reset); end
        end
        #3 forced = 1'b1;
        #1;
        checks++; if (n_reset !== 1'b0) begin errors++; $display("FAIL reassert_immediate got=%b exp=0", n_reset); end
        @(posedge clock);
        #3 forced = 1'b0;
        fall_edge = edge_cnt;
        for (int i = 0; i < 22; i++) begin
            @(negedge clock);
            checks++; if (n_reset !== model_nres(forced, fall_edge, edge_cnt)) begin errors++; $display("FAIL reassert_release edge=%0d got=%b exp=%b", edge_cnt, n_reset, model_nres(forced, fall_edge, edge_cnt)); end
        end
        checks++; if (rise_cnt !== r0 + 1) begin errors++; $display("FAIL reassert_rises got=%0d exp=%0d", rise_cnt - r0, 1); end
    endtask

    task automatic test_random();
        int w, n, g;
        for (int k = 0; k < 14; k++) begin
            @(posedge clock);
            #2 forced = 1'b1;
            #1;
            checks++; if (n_reset !== 1'b0) begin errors++; $display("FAIL rand_immediate k=%0d got=%b exp=0", k, n_reset); end
            if ($urandom_range(1) == 0) begin
                w = $urandom_range(6, 1);
                #(w) forced = 1'b0;
                fall_edge = edge_cnt;
            end else begin
                n = $urandom_range(4, 1);
                repeat (n) begin
                    @(negedge clock);
                    checks++; if (n_reset !== 1'b0) begin errors++; $display("FAIL rand_held edge=%0d got=%b exp=0", edge_cnt, n_reset); end
                end
                @(posedge clock);
                #3 forced = 1'b0;
                fall_edge = edge_cnt;
            end
            g = $urandom_range(24, 0);
            repeat (g) begin
                @(negedge clock);
                checks++; if (n_reset !== model_nres(forced, fall_edge, edge_cnt)) begin errors++; $display("FAIL rand_release edge=%0d got=%b exp=%b", edge_cnt, n_reset, model_nres(forced, fall_edge, edge_cnt)); end
                checks++; if (n_limited !== 1'b1) begin errors++; $display("FAIL rand_nlim edge=%0d got=%b exp=1", edge_cnt, n_limited); end
            end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checks++; if (n_reset !== model_nres(forced, fall_edge, edge_cnt)) begin errors++; $display("FAIL rand_drain edge=%0d got=%b exp=%b", edge_cnt, n_reset, model_nres(forced, fall_edge, edge_cnt)); end
        end
    endtask

    task automatic test_clock_stop();
        int e0;
        @(negedge clock);
        forced = 1'b1;
        #1 clk_en = 1'b0;
        checks++; if (n_reset !== 1'b0) begin errors++; $display("FAIL stop_immediate got=%b exp=0", n_reset); end
        e0 = edge_cnt;
        #500;
        checks++; if (n_reset !== 1'b0) begin errors++; $display("FAIL stop_nres got=%b exp=0", n_reset); end
        checks++; if (n_limited !== 1'b1) begin errors++; $display("FAIL stop_nlim got=%b exp=1", n_limited); end
        checks++; if (edge_cnt !== e0) begin errors++; $display("FAIL stop_clock edges=%0d exp=%0d", edge_cnt, e0); end
        clk_en = 1'b1;
        repeat (3) @(posedge clock);
        #3 forced = 1'b0;
        fall_edge = edge_cnt;
        for (int i = 0; i < 22; i++) begin
            @(negedge clock);
            checks++; if (n_reset !== model_nres(forced, fall_edge, edge_cnt)) begin errors++; $display("FAIL stop_release edge=%0d got=%b exp=%b", edge_cnt, n_reset, model_nres(forced, fall_edge, edge_cnt)); end
        end
    endtask

    initial begin
        test_reset();
        test_soft_reset();
        test_glitch();
        test_reassert();
        test_random();
        test_clock_stop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
